pdp_rd_req_sched: RTL and testbench

- Read-request scheduler between the PDP RDMA request generator and the two DMA read ports, MCIF and CVIF.
- Steers each request by its ram_type bit.
- Enforces latency-FIFO credit limits per port and drains the old port before switching, so responses return in order.
- Forwards credit-return pops to the interfaces.

---
 rtl/pdp_rd_req_sched.sv | 127 ++++++++++++
 tb/tb_pdp_rd_req_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_rd_req_sched.sv
// pdp_rd_req_sched: steers PDP read requests to MCIF/CVIF with per-port latency-FIFO credits and in-order port switching.
// Optional PDP_RD_SCHED_PERF_EN adds a saturating upstream stall counter (stall_cnt).
module pdp_rd_req_sched #(
    parameter int ADDR_W    = 64,
    parameter int SIZE_W    = 15,
    parameter int LAT_DEPTH = 256,
    parameter int CNT_W     = 9
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W+SIZE_W-1:0] req_pd,
    input  logic                     req_ram_type,
    output logic                     pdp2mcif_rd_req_valid,
    input  logic                     pdp2mcif_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0] pdp2mcif_rd_req_pd,
    output logic                     pdp2cvif_rd_req_valid,
    input  logic                     pdp2cvif_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0] pdp2cvif_rd_req_pd,
    input  logic                     mc_lat_fifo_pop,
    input  logic                     cv_lat_fifo_pop,
    output logic                     pdp2mcif_rd_cdt_lat_fifo_pop,
    output logic                     pdp2cvif_rd_cdt_lat_fifo_pop,
    output logic [CNT_W-1:0]         mc_outstanding,
    output logic [CNT_W-1:0]         cv_outstanding,
    output logic                     cdt_err
`ifdef PDP_RD_SCHED_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);
    localparam int PD_W = ADDR_W + SIZE_W;
    localparam logic [SIZE_W:0] DEPTH = (SIZE_W+1)'(LAT_DEPTH);

    typedef enum logic [2:0] {IDLE, MC, CV, DRAIN_MC, DRAIN_CV} state_t;

    state_t            state_q, state_d;
    logic              mc_vld_q, mc_vld_d, cv_vld_q, cv_vld_d;
    logic [PD_W-1:0]   mc_pd_q, mc_pd_d, cv_pd_q, cv_pd_d;
    logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d, cv_cnt_q, cv_cnt_d;
    logic              err_q, err_d, mc_pop_q, cv_pop_q;
    logic [SIZE_W:0]   atoms, mc_room, cv_room;
    logic              tgt_mc, elig, empty, allow, mc_acc, cv_acc, all_idle;

    assign tgt_mc   = req_ram_type;
    assign atoms    = {1'b0, req_pd[PD_W-1:ADDR_W]} + (SIZE_W+1)'(1);
    assign mc_room  = DEPTH - (SIZE_W+1)'(mc_cnt_q);
    assign cv_room  = DEPTH - (SIZE_W+1)'(cv_cnt_q);
    assign elig     = atoms <= (tgt_mc ? mc_room : cv_room);
    assign empty    = tgt_mc ? !mc_vld_q : !cv_vld_q;
    assign allow    = state_q == IDLE || (state_q == MC && tgt_mc) || (state_q == CV && !tgt_mc);
    assign req_ready = req_valid && elig && empty && allow;
    assign mc_acc   = req_ready && tgt_mc;
    assign cv_acc   = req_ready && !tgt_mc;
    assign all_idle = mc_cnt_q == '0 && cv_cnt_q == '0 && !mc_vld_q && !cv_vld_q && !req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_ready) state_d = tgt_mc ? MC : CV;
            MC:       state_d = (req_valid && !tgt_mc) ? DRAIN_MC : all_idle ? IDLE : MC;
            CV:       state_d = (req_valid && tgt_mc) ? DRAIN_CV : all_idle ? IDLE : CV;
            DRAIN_MC: if (!mc_vld_q && mc_cnt_q == '0) state_d = CV;
            DRAIN_CV: if (!cv_vld_q && cv_cnt_q == '0) state_d = MC;
            default:  state_d = IDLE;
        endcase
    end

    // A pop with nothing outstanding is ignored for counting and flagged instead.
    always_comb begin
        mc_vld_d = mc_acc || (mc_vld_q && !pdp2mcif_rd_req_ready);
        cv_vld_d = cv_acc || (cv_vld_q && !pdp2cvif_rd_req_ready);
        mc_pd_d  = mc_acc ? req_pd : mc_pd_q;
        cv_pd_d  = cv_acc ? req_pd : cv_pd_q;
        mc_cnt_d = mc_cnt_q + (mc_acc ? atoms[CNT_W-1:0] : '0) - CNT_W'(mc_lat_fifo_pop && mc_cnt_q != '0);
        cv_cnt_d = cv_cnt_q + (cv_acc ? atoms[CNT_W-1:0] : '0) - CNT_W'(cv_lat_fifo_pop && cv_cnt_q != '0);
        err_d    = err_q || (mc_lat_fifo_pop && mc_cnt_q == '0) || (cv_lat_fifo_pop && cv_cnt_q == '0);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= IDLE;
            mc_vld_q <= 1'b0;
            cv_vld_q <= 1'b0;
            mc_pd_q  <= '0;
            cv_pd_q  <= '0;
            mc_cnt_q <= '0;
            cv_cnt_q <= '0;
            err_q    <= 1'b0;
            mc_pop_q <= 1'b0;
            cv_pop_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_vld_q <= mc_vld_d;
            cv_vld_q <= cv_vld_d;
            mc_pd_q  <= mc_pd_d;
            cv_pd_q  <= cv_pd_d;
            mc_cnt_q <= mc_cnt_d;
            cv_cnt_q <= cv_cnt_d;
            err_q    <= err_d;
            mc_pop_q <= mc_lat_fifo_pop;
            cv_pop_q <= cv_lat_fifo_pop;
        end
    end

    assign pdp2mcif_rd_req_valid        = mc_vld_q;
    assign pdp2mcif_rd_req_pd           = mc_pd_q;
    assign pdp2cvif_rd_req_valid        = cv_vld_q;
    assign pdp2cvif_rd_req_pd           = cv_pd_q;
    assign pdp2mcif_rd_cdt_lat_fifo_pop = mc_pop_q;
    assign pdp2cvif_rd_cdt_lat_fifo_pop = cv_pop_q;
    assign mc_outstanding               = mc_cnt_q;
    assign cv_outstanding               = cv_cnt_q;
    assign cdt_err                      = err_q;

`ifdef PDP_RD_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) stall_q <= '0;
        else stall_q <= stall_q + 32'(req_valid && !req_ready && stall_q != '1);
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pdp_rd_req_sched.sv
// tb_pdp_rd_req_sched: scoreboard bench for the PDP read-request scheduler.
module tb_pdp_rd_req_sched;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        req_valid = 1'b0, req_ram_type = 1'b0, req_ready;
    logic [78:0] req_pd = '0;
    logic        mc_valid, cv_valid, mc_ready = 1'b1, cv_ready = 1'b1;
    logic [78:0] mc_pd, cv_pd;
    logic        mc_pop = 1'b0, cv_pop = 1'b0, mc_cdt, cv_cdt, cdt_err;
    logic [8:0]  mc_out, cv_out;
    logic [78:0] mc_q[$], cv_q[$];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pdp_rd_req_sched dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_pd(req_pd), .req_ram_type(req_ram_type),
        .pdp2mcif_rd_req_valid(mc_valid), .pdp2mcif_rd_req_ready(mc_ready), .pdp2mcif_rd_req_pd(mc_pd),
        .pdp2cvif_rd_req_valid(cv_valid), .pdp2cvif_rd_req_ready(cv_ready), .pdp2cvif_rd_req_pd(cv_pd),
        .mc_lat_fifo_pop(mc_pop), .cv_lat_fifo_pop(cv_pop),
        .pdp2mcif_rd_cdt_lat_fifo_pop(mc_cdt), .pdp2cvif_rd_cdt_lat_fifo_pop(cv_cdt),
        .mc_outstanding(mc_out), .cv_outstanding(cv_out), .cdt_err(cdt_err)
    );

    // Downstream transfers complete at the next posedge; values are stable at the negedge before it.
    always @(negedge clk) begin
        if (rstn) begin
            if (mc_valid && mc_ready) begin
                total++;
                if (mc_q.size() == 0) begin bad++; $display("FAIL mc_xfer: unexpected pd %0h", mc_pd); end
                else begin
                    logic [78:0] e;
                    e = mc_q.pop_front();
                    if (mc_pd !== e) begin bad++; $display("FAIL mc_xfer: got %0h want %0h", mc_pd, e); end
                end
            end
            if (cv_valid && cv_ready) begin
                total++;
                if (cv_q.size() == 0) begin bad++; $display("FAIL cv_xfer: unexpected pd %0h", cv_pd); end
                else begin
                    logic [78:0] e;
                    e = cv_q.pop_front();
                    if (cv_pd !== e) begin bad++; $display("FAIL cv_xfer: got %0h want %0h", cv_pd, e); end
                end
            end
            if (mc_valid && cv_valid) begin
                total++; bad++;
                $display("FAIL both_valid: got 1 want 0");
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mc, input logic [14:0] sz, input logic [63:0] a);
        bit ok = 0;
        req_valid = 1'b1; req_ram_type = mc; req_pd = {sz, a};
        for (int i = 0; i < 400 && !ok; i++) begin
            #1;
            if (req_ready) begin
                ok = 1;
                if (mc) mc_q.push_back(req_pd); else cv_q.push_back(req_pd);
            end
            tick();
        end
        req_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL send_accept: got timeout want accept (pd %0h)", {sz, a}); end
    endtask

    task automatic pops(input logic mc, input int n);
        for (int i = 0; i < n; i++) begin
            if (mc) mc_pop = 1'b1; else cv_pop = 1'b1;
            tick();
        end
        mc_pop = 1'b0; cv_pop = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        total++;
        if ({mc_valid, cv_valid, req_ready, mc_cdt, cv_cdt, cdt_err} !== 6'b0) begin
            bad++; $display("FAIL rst_flags: got %b want 0", {mc_valid, cv_valid, req_ready, mc_cdt, cv_cdt, cdt_err});
        end
        total++;
        if ({mc_out, cv_out} !== 18'b0) begin bad++; $display("FAIL rst_cnt: got %0h want 0", {mc_out, cv_out}); end
        total++;
        if ((mc_pd | cv_pd) !== 79'b0) begin bad++; $display("FAIL rst_pd: got %0h want 0", mc_pd | cv_pd); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_mc;
        mc_ready = 1'b1;
        send(1'b1, 15'd3, 64'h1000);
        #1;
        total++;
        if (mc_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", mc_valid); end
        total++;
        if (mc_pd !== {15'd3, 64'h1000}) begin bad++; $display("FAIL single_pd: got %0h want %0h", mc_pd, {15'd3, 64'h1000}); end
        total++;
        if (mc_out !== 9'd4) begin bad++; $display("FAIL single_out: got %0d want 4", mc_out); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mc_pop = 1'b1;
            #1;
            total++;
            if (mc_cdt !== 1'b0) begin bad++; $display("FAIL cdt_lag_pre: got %b want 0", mc_cdt); end
            tick();
            mc_pop = 1'b0;
            #1;
            total++;
            if (mc_cdt !== 1'b1) begin bad++; $display("FAIL cdt_lag_post: got %b want 1", mc_cdt); end
            total++;
            if (mc_out !== 9'(3 - i)) begin bad++; $display("FAIL single_pop_out: got %0d want %0d", mc_out, 3 - i); end
            tick();
        end
    endtask

    task automatic test_credit;
        send(1'b1, 15'd127, 64'h2000);
        send(1'b1, 15'd127, 64'h3000);
        #1;
        total++;
        if (mc_out !== 9'd256) begin bad++; $display("FAIL credit_full: got %0d want 256", mc_out); end
        req_valid = 1'b1; req_ram_type = 1'b1; req_pd = {15'd0, 64'h4000};
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req_ready !== 1'b0) begin bad++; $display("FAIL credit_stall: got %b want 0", req_ready); end
            tick();
        end
        mc_pop = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL credit_stall_pop: got %b want 0", req_ready); end
        tick();
        mc_pop = 1'b0;
        #1;
        total++;
        if (mc_out !== 9'd255) begin bad++; $display("FAIL credit_255: got %0d want 255", mc_out); end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL credit_ready: got %b want 1", req_ready); end
        mc_q.push_back(req_pd);
        tick();
        req_valid = 1'b0;
        #1;
        total++;
        if (mc_out !== 9'd256) begin bad++; $display("FAIL credit_refill: got %0d want 256", mc_out); end
        pops(1'b1, 256);
        #1;
        total++;
        if (mc_out !== 9'd0) begin bad++; $display("FAIL credit_drain: got %0d want 0", mc_out); end
    endtask

    task automatic test_switch;
        send(1'b1, 15'd7, 64'h5000);
        req_valid = 1'b1; req_ram_type = 1'b0; req_pd = {15'd0, 64'h6000};
        for (int i = 0; i < 8; i++) begin
            mc_pop = 1'b1;
            #1;
            total++;
            if ({req_ready, cv_valid} !== 2'b00) begin bad++; $display("FAIL drain_block: got %b want 00", {req_ready, cv_valid}); end
            tick();
        end
        mc_pop = 1'b0;
        #1;
        total++;
        if ({mc_out, req_ready} !== 10'd0) begin bad++; $display("FAIL drain_last: got %0h want 0", {mc_out, req_ready}); end
        tick();
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL switch_ready: got %b want 1", req_ready); end
        cv_q.push_back(req_pd);
        tick();
        req_valid = 1'b0;
        #1;
        total++;
        if (cv_valid !== 1'b1) begin bad++; $display("FAIL switch_cv_valid: got %b want 1", cv_valid); end
        tick();
        pops(1'b0, 1);
    endtask

    task automatic test_back_to_back;
        logic [78:0] hold;
        cv_ready = 1'b0;
        send(1'b0, 15'd2, 64'h7000);
        hold = {15'd2, 64'h7000};
        req_valid = 1'b1; req_ram_type = 1'b0; req_pd = {15'd0, 64'h8000};
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({cv_valid, req_ready} !== 2'b10) begin bad++; $display("FAIL bp_ctrl: got %b want 10", {cv_valid, req_ready}); end
            total++;
            if (cv_pd !== hold) begin bad++; $display("FAIL bp_pd: got %0h want %0h", cv_pd, hold); end
            tick();
        end
        cv_ready = 1'b1;
        #1;
        tick();
        #1;
        total++;
        if ({cv_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got %b want 01", {cv_valid, req_ready}); end
        cv_q.push_back(req_pd);
        tick();
        req_valid = 1'b0;
        #1;
        total++;
        if (cv_valid !== 1'b1) begin bad++; $display("FAIL bp_second: got %b want 1", cv_valid); end
        tick();
        pops(1'b0, 4);
        #1;
        total++;
        if (cv_out !== 9'd0) begin bad++; $display("FAIL bp_drain: got %0d want 0", cv_out); end
    endtask

    task automatic test_simul_and_err;
        send(1'b1, 15'd2, 64'h9000);
        #1;
        total++;
        if (mc_out !== 9'd3) begin bad++; $display("FAIL simul_pre: got %0d want 3", mc_out); end
        tick();
        req_valid = 1'b1; req_ram_type = 1'b1; req_pd = {15'd1, 64'hA000};
        mc_pop = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL simul_ready: got %b want 1", req_ready); end
        mc_q.push_back(req_pd);
        tick();
        req_valid = 1'b0; mc_pop = 1'b0;
        #1;
        total++;
        if (mc_out !== 9'd4) begin bad++; $display("FAIL simul_out: got %0d want 4", mc_out); end
        pops(1'b1, 4);
        #1;
        total++;
        if ({mc_out, cdt_err} !== 10'd0) begin bad++; $display("FAIL err_pre: got %0h want 0", {mc_out, cdt_err}); end
        mc_pop = 1'b1;
        tick();
        mc_pop = 1'b0;
        #1;
        total++;
        if ({mc_out, cdt_err} !== 10'd1) begin bad++; $display("FAIL err_set: got %0h want 1", {mc_out, cdt_err}); end
        repeat (2) tick();
        total++;
        if (cdt_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", cdt_err); end
    endtask

    task automatic test_reset_mid;
        mc_ready = 1'b0;
        send(1'b1, 15'd9, 64'hB000);
        #1;
        total++;
        if ({mc_valid, mc_out} !== {1'b1, 9'd10}) begin bad++; $display("FAIL rmid_pre: got %0h want %0h", {mc_valid, mc_out}, {1'b1, 9'd10}); end
        rstn = 1'b0;
        #1;
        total++;
        if ({mc_valid, mc_out, cdt_err, req_ready} !== 12'd0) begin bad++; $display("FAIL rmid_now: got %0h want 0", {mc_valid, mc_out, cdt_err, req_ready}); end
        total++;
        if (mc_pd !== 79'd0) begin bad++; $display("FAIL rmid_pd: got %0h want 0", mc_pd); end
        mc_q.delete();
        repeat (2) tick();
        rstn = 1'b1; mc_ready = 1'b1;
        tick();
        req_valid = 1'b1; req_ram_type = 1'b0; req_pd = {15'd0, 64'hC000};
        #1;
        total++;
        if ({mc_out, cv_out, req_ready} !== 19'd1) begin bad++; $display("FAIL rmid_idle: got %0h want 1", {mc_out, cv_out, req_ready}); end
        cv_q.push_back(req_pd);
        tick();
        req_valid = 1'b0;
        tick();
        pops(1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_single_mc();
        test_credit();
        test_switch();
        test_back_to_back();
        test_simul_and_err();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (mc_q.size() + cv_q.size() != 0) begin
            bad++; $display("FAIL sb_empty: got %0d left want 0", mc_q.size() + cv_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
